compute_scheduler: RTL
======================

Name: compute_scheduler

Overview:
Sequences the force-compute datapath: it walks every home cell, then every reference particle slot in that cell, then every neighbor particle slot. For each step it drives one reference address and one neighbor slot index to the cell memories that feed the 14-wide particle filter bank.
After the last issue it raises read_controller_done toward the compute pipeline and waits for the pipeline's aggregated done before reporting completion.
It sits between the top-level run control and the cell-memory read ports / compute pipeline.

Parameters:
N_CELLS, 64, number of home cells swept; cell index width is fixed at 8 bits, so 1..256.
PPC, 32, particle slots per cell.
SLOT_W, 5, slot index width; must equal clog2(PPC).

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-low reset; low on a rising edge resets the block
start  in  1  one-cycle pulse; honoured only in IDLE or DONE
count_cell  out  8  home cell whose particle count is being looked up
count_in  in  SLOT_W+1  particle count of count_cell; valid exactly 1 cycle after count_cell is driven
issue_valid  out  1  ref_cell/ref_slot/nbr_slot are valid this cycle
issue_ready  in  1  datapath accepts the issue (pair-queue backpressure)
ref_cell  out  8  home cell of the current reference particle
ref_slot  out  SLOT_W  reference particle slot
nbr_slot  out  SLOT_W  neighbor slot, broadcast to all 14 neighbor-cell memories
read_controller_done  out  1  all issues sent; goes to the compute pipeline
pipeline_done  in  1  aggregated done from the compute pipeline
busy  out  1  high in every state except IDLE and DONE
done  out  1  high while in DONE
pairs_issued  out  32  count of accepted issues this run

Behaviour:
- States: IDLE, FETCH, LATCH, ISSUE, NEXT_CELL, DRAIN, DONE. One state per cycle unless noted otherwise.
- Reset (reset low at a clock edge):
  - state=IDLE; cell, p, q, ref_count and pairs_issued = 0.
  - All outputs 0.
  - Reset overrides every state, including mid-ISSUE and DRAIN; no partial completion is signalled.
- IDLE/DONE + start:
  - cell=0, pairs_issued=0, done falls.
  - Next state FETCH.
  - start is ignored while busy.
- FETCH: count_cell=cell. Next state LATCH.
- LATCH:
  - Register ref_count = min(count_in, PPC); a count above PPC saturates to PPC.
  - If ref_count==0, go to NEXT_CELL.
  - Otherwise p=0, q=0, go to ISSUE.
- ISSUE:
  - issue_valid=1, with ref_cell=cell, ref_slot=p, nbr_slot=q.
  - Outputs are held stable while issue_valid && !issue_ready.
  - Issue acceptance is the edge with issue_valid && issue_ready. On acceptance: pairs_issued+=1, then:
    - q<PPC-1: q+=1.
    - q==PPC-1 and p<ref_count-1: q=0, p+=1.
    - q==PPC-1 and p==ref_count-1: go to NEXT_CELL.
  - Throughput is one issue per cycle while issue_ready is held high.
  - The neighbor sweep is always the full PPC slots; empty slots are dropped by the filters, not here.
- NEXT_CELL:
  - issue_valid=0.
  - If cell==N_CELLS-1, go to DRAIN.
  - Otherwise cell+=1, go to FETCH.
- DRAIN:
  - read_controller_done=1.
  - Go to DONE on the first edge where pipeline_done==1.
  - pipeline_done is ignored in every other state.
- DONE:
  - done=1, busy=0; read_controller_done stays 1.
  - pairs_issued holds its value until the next start.
- Overhead per cell: 3 cycles (FETCH, LATCH, NEXT_CELL). An empty cell therefore costs exactly 3 cycles.
- Counters: pairs_issued wraps modulo 2^32 with no saturation. p, q and cell never exceed their bounds.

Test Plan:
- Basic sweep, N_CELLS=2, PPC=4, counts {2,0}, issue_ready=1:
  - start -> 8 issues with (ref_cell,ref_slot,nbr_slot) in order (0,0,0),(0,0,1)…(0,1,3), none for cell 1.
  - read_controller_done rises, pairs_issued=8.
  - pipeline_done=1 -> done=1 next cycle.
- Backpressure: issue_ready low for 5 cycles mid-run -> outputs held stable, no pairs_issued increment, ordering unchanged, total still 8.
- Saturation: count_in=7 with PPC=4 -> exactly 16 issues for that cell; ref_slot never exceeds 3.
- Drain wait: pipeline_done held 0 for 20 cycles after the last issue -> stays in DRAIN (busy=1, done=0); rises -> DONE.
- Reset mid-ISSUE (reset=0 for one edge) -> next cycle all outputs 0, state IDLE; a subsequent start restarts at cell 0 with pairs_issued=0.
- start pulsed while busy -> ignored, sequence unaffected. start in DONE -> new run begins at FETCH, done falls.

Source files
------------

// File: rtl/compute_scheduler.sv
// compute_scheduler: walks home cells, reference slots and neighbor slots, issuing one
// (ref_cell, ref_slot, nbr_slot) triple per accepted cycle to the cell-memory read ports.
// Latency: 3 overhead cycles per cell plus one cycle per issue; issues stall while issue_ready is low.
//
// Ports:
//   clk, reset (sync, active-low), start        - run control
//   count_cell / count_in                        - per-cell particle count lookup (1-cycle read)
//   issue_valid / issue_ready, ref_cell, ref_slot, nbr_slot - issue handshake toward the filters
//   read_controller_done / pipeline_done         - end-of-issue handoff to the compute pipeline
//   busy, done, pairs_issued                     - status
module compute_scheduler #(
  parameter int N_CELLS = 64,
  parameter int PPC     = 32,
  parameter int SLOT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [7:0]        count_cell,
  input  logic [SLOT_W:0]   count_in,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [7:0]        ref_cell,
  output logic [SLOT_W-1:0] ref_slot,
  output logic [SLOT_W-1:0] nbr_slot,
  output logic              read_controller_done,
  input  logic              pipeline_done,
  output logic              busy,
  output logic              done,
  output logic [31:0]       pairs_issued
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_NEXT_CELL,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [7:0]        LAST_CELL = 8'(N_CELLS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PPC - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W:0]   PPC_W     = (SLOT_W + 1)'(PPC);
  localparam logic [SLOT_W:0]   CNT_ONE   = (SLOT_W + 1)'(1);

  state_t            state_q, state_d;
  logic [7:0]        cell_q, cell_d;
  logic [SLOT_W-1:0] p_q, p_d;
  logic [SLOT_W-1:0] q_q, q_d;
  logic [SLOT_W:0]   ref_count_q, ref_count_d;
  logic [31:0]       pairs_q, pairs_d;

  logic [SLOT_W:0]   count_sat;
  logic              last_ref;

  // Counts above PPC come from a corrupt/over-full cell; clamp so p stays in range.
  assign count_sat = (count_in > PPC_W) ? PPC_W : count_in;
  // ref_count is never 0 while in ISSUE, so p+1 == ref_count marks the last reference slot.
  assign last_ref  = (({1'b0, p_q} + CNT_ONE) == ref_count_q);

  always_comb begin
    state_d     = state_q;
    cell_d      = cell_q;
    p_d         = p_q;
    q_d         = q_q;
    ref_count_d = ref_count_q;
    pairs_d     = pairs_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cell_d  = 8'd0;
          pairs_d = 32'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ref_count_d = count_sat;
        if (count_sat == '0) begin
          state_d = S_NEXT_CELL;
        end else begin
          p_d     = '0;
          q_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          pairs_d = pairs_q + 32'd1;
          if (q_q != LAST_SLOT) begin
            q_d = q_q + SLOT_ONE;
          end else if (!last_ref) begin
            q_d = '0;
            p_d = p_q + SLOT_ONE;
          end else begin
            state_d = S_NEXT_CELL;
          end
        end
      end
      S_NEXT_CELL: begin
        if (cell_q == LAST_CELL) begin
          state_d = S_DRAIN;
        end else begin
          cell_d  = cell_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (pipeline_done) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cell_q      <= 8'd0;
      p_q         <= '0;
      q_q         <= '0;
      ref_count_q <= '0;
      pairs_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cell_q      <= cell_d;
      p_q         <= p_d;
      q_q         <= q_d;
      ref_count_q <= ref_count_d;
      pairs_q     <= pairs_d;
    end
  end

  // All outputs are decoded from registers, so they are glitch-free and stable under stall.
  assign count_cell           = cell_q;
  assign issue_valid          = (state_q == S_ISSUE);
  assign ref_cell             = cell_q;
  assign ref_slot             = p_q;
  assign nbr_slot             = q_q;
  assign read_controller_done = (state_q == S_DRAIN) || (state_q == S_DONE);
  assign busy                 = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done                 = (state_q == S_DONE);
  assign pairs_issued         = pairs_q;

endmodule
